prometheus_fx3_stream_in: RTL and testbench

//   FPGA-side writer for the FX3 slave-FIFO streamIN path: streams an incrementing 32-bit pattern

---
 rtl/prometheus_fx3_stream_in.sv | 111 +++++++++++
 tb/tb_prometheus_fx3_stream_in.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/prometheus_fx3_stream_in.sv
// FX3 slave-FIFO streamIN writer: pushes an incrementing pattern over GPIF while streamIN mode is
// selected, gated by thread-ready (flag A) and watermark (flag B), with PKTEND on mode exit.
module prometheus_fx3_stream_in #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned WM_WR_CYCLES  = 3,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                  clk_100,
  input  logic                  rst_n,
  input  logic                  stream_in_mode_selected,
  input  logic                  i_gpif_in_ch0_rdy_d,
  input  logic                  i_gpif_out_ch0_rdy_d,
  output logic                  o_gpif_we_n_stream_in_,
  output logic                  o_gpif_pktend_n_stream_in_,
  output logic [DATA_WIDTH-1:0] o_data_to_fx3,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FLAGB,
    WRITE,
    WR_DELAY,
    PKTEND,
    SETTLE
  } state_t;

  localparam logic [3:0] WM_LOAD     = 4'(WM_WR_CYCLES - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [3:0]            wr_delay_cnt;
  logic [3:0]            settle_cnt;
  logic [DATA_WIDTH-1:0] pattern;
  logic                  we_n;
  logic                  pktend_n;

  wire mode  = stream_in_mode_selected;
  wire flag_a = i_gpif_in_ch0_rdy_d;
  wire flag_b = i_gpif_out_ch0_rdy_d;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_delay_cnt <= '0;
      settle_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mode && flag_a) state <= WAIT_FLAGB;
        end
        WAIT_FLAGB: begin
          if (!mode)       state <= IDLE;
          else if (flag_b) state <= WRITE;
        end
        WRITE: begin
          // Mode exit wins over a simultaneous watermark so the short packet is always closed.
          if (!mode) begin
            state <= PKTEND;
          end else if (!flag_b) begin
            state        <= WR_DELAY;
            wr_delay_cnt <= WM_LOAD;
          end
        end
        WR_DELAY: begin
          if (wr_delay_cnt == '0) begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end else begin
            wr_delay_cnt <= wr_delay_cnt - 4'd1;
          end
        end
        PKTEND: begin
          state      <= SETTLE;
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= IDLE;
          else                  settle_cnt <= settle_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    we_n     = 1'b1;
    pktend_n = 1'b1;
    case (state)
      WRITE, WR_DELAY: we_n = 1'b0;
      PKTEND: begin
        we_n     = 1'b0;
        pktend_n = 1'b0;
      end
      default: ;
    endcase
  end

  // Pattern advances after each written word and survives across bursts.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n)     pattern <= '0;
    else if (!we_n) pattern <= pattern + DATA_ONE;
  end

  assign o_gpif_we_n_stream_in_     = we_n;
  assign o_gpif_pktend_n_stream_in_ = pktend_n;
  assign o_data_to_fx3              = pattern;
  assign o_busy                     = (state != IDLE);

endmodule

// File: tb/tb_prometheus_fx3_stream_in.sv
// Scoreboard bench for prometheus_fx3_stream_in: expected written words are queued per burst and
// popped by an independent monitor on every write strobe.
module tb_prometheus_fx3_stream_in;
  localparam int unsigned DW = 32;
  localparam int unsigned WM = 3;
  localparam int unsigned ST = 3;

  logic          clk_100 = 1'b0;
  logic          rst_n;
  logic          mode;
  logic          flag_a;
  logic          flag_b;
  logic          we_n;
  logic          pktend_n;
  logic [DW-1:0] data;
  logic          busy;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] exp_cnt = '0;

  prometheus_fx3_stream_in #(
    .DATA_WIDTH(DW),
    .WM_WR_CYCLES(WM),
    .SETTLE_CYCLES(ST)
  ) dut (
    .clk_100(clk_100),
    .rst_n(rst_n),
    .stream_in_mode_selected(mode),
    .i_gpif_in_ch0_rdy_d(flag_a),
    .i_gpif_out_ch0_rdy_d(flag_b),
    .o_gpif_we_n_stream_in_(we_n),
    .o_gpif_pktend_n_stream_in_(pktend_n),
    .o_data_to_fx3(data),
    .o_busy(busy)
  );

  always #5 clk_100 = ~clk_100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write strobe must match the next queued word.
  always @(negedge clk_100) begin
    if (rst_n === 1'b1) begin
      if (we_n === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          chk("word_data", 64'(data), 64'(e[DW-1:0]));
          chk("word_pktend_n", 64'(pktend_n), 64'(!e[DW]));
          chk("word_busy", 64'(busy), 64'd1);
        end
      end else if (pktend_n !== 1'b1) begin
        chk("pktend_without_we", 64'(pktend_n), 64'd1);
      end
    end
  end

  task automatic queue_words(input int unsigned words, input bit last_pkt);
    for (int unsigned i = 0; i < words; i++) begin
      exp_q.push_back({(last_pkt && i == words - 1), exp_cnt});
      exp_cnt = exp_cnt + 1;
    end
  endtask

  // Raise mode/flags and return at the negedge of the first WRITE cycle.
  task automatic start_burst(input int unsigned da, input int unsigned db);
    bit seen;
    @(negedge clk_100);
    mode = 1'b1; flag_a = 1'b0; flag_b = 1'b0;
    repeat (da) @(negedge clk_100);
    flag_a = 1'b1;
    repeat (db) @(negedge clk_100);
    flag_b = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk_100);
      if (we_n === 1'b0) seen = 1'b1;
    end
    chk("write_start_timeout", 64'(seen), 64'd1);
  endtask

  task automatic finish_burst();
    int unsigned settle;
    bit idle;
    settle = 0;
    idle = 1'b0;
    for (int t = 0; t < 100 && !idle; t++) begin
      @(negedge clk_100);
      if (busy === 1'b0) idle = 1'b1;
      else if (we_n === 1'b1) settle++;
    end
    chk("return_idle", 64'(idle), 64'd1);
    chk("settle_len", 64'(settle), 64'(ST));
    chk("burst_drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_burst(input int unsigned n, input bit pk, input int unsigned da,
                           input int unsigned db, input bit fb_drop);
    queue_words(pk ? n + 1 : n + WM, pk);
    start_burst(da, db);
    repeat (n - 1) @(negedge clk_100);
    if (pk) begin
      mode = 1'b0; flag_a = 1'b0;
      if (fb_drop) flag_b = 1'b0;
    end else begin
      flag_b = 1'b0;
      @(negedge clk_100);
      mode = 1'b0; flag_a = 1'b0;
    end
    finish_burst();
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b1; flag_a = 1'b1; flag_b = 1'b1;
    repeat (3) @(negedge clk_100);
    chk("rst_we_n", 64'(we_n), 64'd1);
    chk("rst_pktend_n", 64'(pktend_n), 64'd1);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    mode = 1'b0;
    @(negedge clk_100);
    rst_n = 1'b1;

    // Mode off: flags alone must not start anything.
    repeat (50) begin
      @(negedge clk_100);
      chk("off_busy", 64'(busy), 64'd0);
      chk("off_data", 64'(data), 64'(exp_cnt));
    end

    // Fixed watermark burst: 10 WRITE cycles, then a second burst continuing the pattern.
    run_burst(10, 1'b0, 0, 0, 1'b0);
    run_burst(4, 1'b0, 1, 2, 1'b0);
    // Mode exit after 5 words in WRITE.
    run_burst(5, 1'b1, 0, 0, 1'b0);

    // Stuck in WAIT_FLAGB, then mode drop returns to IDLE in one edge.
    @(negedge clk_100);
    mode = 1'b1; flag_a = 1'b1; flag_b = 1'b0;
    repeat (3) @(negedge clk_100);
    repeat (5) begin
      @(negedge clk_100);
      chk("wfb_busy", 64'(busy), 64'd1);
      chk("wfb_we_n", 64'(we_n), 64'd1);
    end
    mode = 1'b0; flag_a = 1'b0;
    @(negedge clk_100);
    chk("wfb_exit_idle", 64'(busy), 64'd0);

    // Randomized bursts of both exit kinds.
    for (int i = 0; i < 20; i++) begin
      run_burst($urandom_range(1, 12), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset during the second WR_DELAY cycle.
    begin
      int unsigned n;
      n = $urandom_range(1, 6);
      queue_words(n + 2, 1'b0);
      start_burst(0, 0);
      repeat (n - 1) @(negedge clk_100);
      flag_b = 1'b0;
      @(negedge clk_100);
      mode = 1'b0; flag_a = 1'b0;
      @(negedge clk_100);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_we_n", 64'(we_n), 64'd1);
      chk("mid_rst_pktend_n", 64'(pktend_n), 64'd1);
      chk("mid_rst_data", 64'(data), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_drain", 64'(exp_q.size()), 64'd0);
      exp_cnt = '0;
      repeat (2) @(negedge clk_100);
      rst_n = 1'b1;
      repeat (5) begin
        @(negedge clk_100);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_pktend_n", 64'(pktend_n), 64'd1);
      end
    end

    // Pattern restarts from zero after reset.
    run_burst(2, 1'b1, 0, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
